// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: MMCM reset/lock sequencing with lock
// qualification, timeout retry, lock-loss recovery and power-down.
module pll_lock_sequencer #(
  parameter int RESET_CYCLES       = 16,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CNT_WIDTH          = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       restart,
  input  logic       pwrdn_req,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       pll_pwrdwn,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] timeout_count,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_READY  = 3'd3,
    S_PWRDN  = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] RST_LAST =
    CNT_WIDTH'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST =
    CNT_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] STB_LAST =
    CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);

  state_t               cur;
  state_t               nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 sync1;
  logic                 locked_s;
  logic                 enter;
  logic                 to_ev;
  logic                 loss_ev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
    end
  end

  always_comb begin
    nxt     = cur;
    enter   = 1'b0;
    to_ev   = 1'b0;
    loss_ev = 1'b0;
    if (pwrdn_req) begin
      nxt = S_PWRDN;
    end else if (cur == S_PWRDN || restart) begin
      // restart inside RESET re-enters it, restarting the count
      nxt   = S_RESET;
      enter = 1'b1;
    end else begin
      unique case (cur)
        S_RESET: begin
          if (cnt == RST_LAST) nxt = S_WAIT;
        end
        S_WAIT: begin
          if (locked_s) begin
            nxt = S_STABLE;
          end else if (cnt == TO_LAST) begin
            nxt   = S_RESET;
            to_ev = 1'b1;
          end
        end
        S_STABLE: begin
          if (!locked_s) nxt = S_WAIT;
          else if (cnt == STB_LAST) nxt = S_READY;
        end
        S_READY: begin
          if (!locked_s) begin
            nxt     = S_RESET;
            loss_ev = 1'b1;
          end
        end
        default: nxt = S_RESET;
      endcase
    end
    if (nxt != cur) enter = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur             <= S_RESET;
      cnt             <= '0;
      pll_rst         <= 1'b1;
      pll_pwrdwn      <= 1'b0;
      ready           <= 1'b0;
      lock_lost       <= 1'b0;
      timeout_count   <= 8'd0;
      lock_loss_count <= 8'd0;
    end else begin
      cur <= nxt;
      // cnt only runs in states that bound it with a compare
      if (enter)
        cnt <= '0;
      else if (cur inside {S_RESET, S_WAIT, S_STABLE})
        cnt <= cnt + CNT_WIDTH'(1);
      pll_rst    <= (nxt == S_RESET) || (nxt == S_PWRDN);
      pll_pwrdwn <= (nxt == S_PWRDN);
      ready      <= (nxt == S_READY);
      lock_lost  <= loss_ev;
      if (to_ev && timeout_count != 8'hff)
        timeout_count <= timeout_count + 8'd1;
      if (loss_ev && lock_loss_count != 8'hff)
        lock_loss_count <= lock_loss_count + 8'd1;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed vector table plus hand-written
// sequences for timeout, saturation and async reset.
module tb_pll_lock_sequencer;

  localparam logic [2:0] RS = 3'd0;
  localparam logic [2:0] WL = 3'd1;
  localparam logic [2:0] ST = 3'd2;
  localparam logic [2:0] RD = 3'd3;
  localparam logic [2:0] PD = 3'd4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       restart = 1'b0;
  logic       pwrdn_req = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       pll_pwrdwn;
  logic       ready;
  logic       lock_lost;
  logic [7:0] timeout_count;
  logic [7:0] lock_loss_count;
  logic [2:0] state;

  typedef struct {
    logic       rs;
    logic       pd;
    logic       lk;
    logic [2:0] st;
    logic       rst;
    logic       pw;
    logic       rdy;
    logic       lost;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  pll_lock_sequencer #(
    .RESET_CYCLES       (4),
    .LOCK_TIMEOUT       (32),
    .LOCK_STABLE_CYCLES (8),
    .CNT_WIDTH          (24)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .restart         (restart),
    .pwrdn_req       (pwrdn_req),
    .pll_locked      (pll_locked),
    .pll_rst         (pll_rst),
    .pll_pwrdwn      (pll_pwrdwn),
    .ready           (ready),
    .lock_lost       (lock_lost),
    .timeout_count   (timeout_count),
    .lock_loss_count (lock_loss_count),
    .state           (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input int n, input logic rs, input logic pd,
                     input logic lk, input logic [2:0] st,
                     input logic rst, input logic pw,
                     input logic rdy, input logic lost);
    vec_t v;
    v.rs = rs; v.pd = pd; v.lk = lk; v.st = st;
    v.rst = rst; v.pw = pw; v.rdy = rdy; v.lost = lost;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic step(input logic rs, input logic pd, input logic lk);
    @(negedge clk);
    restart = rs;
    pwrdn_req = pd;
    pll_locked = lk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hi;
    int n;
    // power-up: reset, then lock after WAIT_LOCK entry
    add(3, 0, 0, 0, RS, 1, 0, 0, 0);
    add(1, 0, 0, 0, WL, 0, 0, 0, 0);
    add(2, 0, 0, 1, WL, 0, 0, 0, 0);
    add(8, 0, 0, 1, ST, 0, 0, 0, 0);
    add(2, 0, 0, 1, RD, 0, 0, 1, 0);
    // lock loss in READY
    add(2, 0, 0, 0, RD, 0, 0, 1, 0);
    add(1, 0, 0, 0, RS, 1, 0, 0, 1);
    add(3, 0, 0, 0, RS, 1, 0, 0, 0);
    add(1, 0, 0, 0, WL, 0, 0, 0, 0);
    // relock with a glitch seen at STABLE cnt=5
    add(2, 0, 0, 1, WL, 0, 0, 0, 0);
    add(4, 0, 0, 1, ST, 0, 0, 0, 0);
    add(1, 0, 0, 0, ST, 0, 0, 0, 0);
    add(1, 0, 0, 1, ST, 0, 0, 0, 0);
    add(1, 0, 0, 1, WL, 0, 0, 0, 0);
    add(8, 0, 0, 1, ST, 0, 0, 0, 0);
    add(1, 0, 0, 1, RD, 0, 0, 1, 0);
    // power-down from READY, then recovery
    add(10, 0, 1, 1, PD, 1, 1, 0, 0);
    add(4, 0, 0, 1, RS, 1, 0, 0, 0);
    add(1, 0, 0, 1, WL, 0, 0, 0, 0);
    add(8, 0, 0, 1, ST, 0, 0, 0, 0);
    add(1, 0, 0, 1, RD, 0, 0, 1, 0);
    // restart, restart inside RESET, restart+pwrdn together
    add(1, 1, 0, 1, RS, 1, 0, 0, 0);
    add(2, 0, 0, 1, RS, 1, 0, 0, 0);
    add(1, 1, 0, 1, RS, 1, 0, 0, 0);
    add(3, 0, 0, 1, RS, 1, 0, 0, 0);
    add(1, 0, 0, 1, WL, 0, 0, 0, 0);
    add(1, 1, 1, 1, PD, 1, 1, 0, 0);
    add(1, 1, 0, 1, RS, 1, 0, 0, 0);
    add(3, 0, 0, 1, RS, 1, 0, 0, 0);
    add(1, 0, 0, 1, WL, 0, 0, 0, 0);
    add(1, 0, 0, 1, ST, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    chk("reset_outputs",
        {29'd0, state, pll_rst, pll_pwrdwn, ready, lock_lost},
        {29'd0, RS, 4'b1000});
    chk("reset_counters", {16'd0, timeout_count, lock_loss_count}, 0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].rs, vecs[i].pd, vecs[i].lk);
      chk($sformatf("vec%0d", i),
          {25'd0, state, pll_rst, pll_pwrdwn, ready, lock_lost},
          {25'd0, vecs[i].st, vecs[i].rst, vecs[i].pw,
           vecs[i].rdy, vecs[i].lost});
    end
    chk("loss_count_after_table", {24'd0, lock_loss_count}, 1);
    chk("timeout_count_after_table", {24'd0, timeout_count}, 0);

    // lock timeouts with pll_locked held low
    @(negedge clk);
    reset_n = 1'b0;
    restart = 1'b0;
    pwrdn_req = 1'b0;
    pll_locked = 1'b0;
    @(posedge clk);
    #1;
    chk("counters_cleared", {16'd0, timeout_count, lock_loss_count}, 0);
    reset_n = 1'b1;
    repeat (35) step(0, 0, 0);
    chk("pre_timeout_state", {29'd0, state}, {29'd0, WL});
    chk("pre_timeout_count", {24'd0, timeout_count}, 0);
    step(0, 0, 0);
    chk("timeout1_state", {29'd0, state}, {29'd0, RS});
    chk("timeout1_rst", {31'd0, pll_rst}, 1);
    chk("timeout1_count", {24'd0, timeout_count}, 1);
    for (int k = 2; k <= 3; k++) begin
      hi = 0;
      for (int c = 0; c < 36; c++) begin
        step(0, 0, 0);
        hi += int'(pll_rst);
      end
      chk($sformatf("rst_high_cycles%0d", k), hi, 4);
      chk($sformatf("timeout%0d_count", k), {24'd0, timeout_count}, k);
    end
    repeat (300 * 36) @(posedge clk);
    #1;
    chk("timeout_saturated", {24'd0, timeout_count}, 8'hff);

    // async reset mid-STABLE
    @(negedge clk);
    pll_locked = 1'b1;
    n = 0;
    while (state != ST && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_stable", {29'd0, state}, {29'd0, ST});
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {29'd0, state, pll_rst, pll_pwrdwn, ready, lock_lost},
        {29'd0, RS, 4'b1000});
    chk("async_reset_counters",
        {16'd0, timeout_count, lock_loss_count}, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
